// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : CPU, probe and RAM command bundle around the two-master arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              hold_cpu;
    logic              owner;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and the RAM model sit on the master side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output hold_cpu, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  owner, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  hold_cpu, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output owner, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one synchronous RAM between a CPU and a debug probe.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int DBG_MAX_BURST = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_arbiter_if.slave   bus
);
    localparam int                    c_STREAK_W   = $clog2(DBG_MAX_BURST + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(DBG_MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [c_STREAK_W-1:0] r_streak;
    logic                  r_cmd_we;
    logic                  r_owner;
    logic                  r_mem_cs;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_cpu_gnt;
    logic                  r_dbg_gnt;
    logic                  r_cpu_rvalid;
    logic                  r_dbg_rvalid;

    logic                  w_cpu_elig;
    logic                  w_cpu_win;
    logic                  w_take;
    logic                  w_we_sel;

    always_comb begin
        w_cpu_elig = bus.cpu_req & ~bus.hold_cpu;
        // The probe normally wins; a saturated streak hands one slot to the CPU.
        w_cpu_win  = w_cpu_elig & (~bus.dbg_req | (r_streak == c_STREAK_MAX));
        w_take     = (r_state == IDLE) & (bus.dbg_req | w_cpu_elig);
        w_we_sel   = w_cpu_win ? bus.cpu_we : bus.dbg_we;
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_nx = ACCESS;
            ACCESS:  w_state_nx = r_cmd_we ? IDLE : RESP;
            RESP:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak     <= '0;
            r_cmd_we     <= 1'b0;
            r_owner      <= 1'b0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_dbg_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            if (w_take) begin
                r_mem_cs    <= 1'b1;
                r_mem_we    <= w_we_sel;
                r_cmd_we    <= w_we_sel;
                r_owner     <= ~w_cpu_win;
                r_cpu_gnt   <= w_cpu_win;
                r_dbg_gnt   <= ~w_cpu_win;
                r_mem_addr  <= w_cpu_win ? bus.cpu_addr  : bus.dbg_addr;
                r_mem_wdata <= w_cpu_win ? bus.cpu_wdata : bus.dbg_wdata;
                if (w_cpu_win)
                    r_streak <= '0;
                else if (w_cpu_elig && (r_streak != c_STREAK_MAX))
                    r_streak <= r_streak + 1'b1;
            end
            // RAM data arrives in the cycle after cs, so rvalid lines up with RESP.
            if ((r_state == ACCESS) && !r_cmd_we) begin
                r_cpu_rvalid <= ~r_owner;
                r_dbg_rvalid <= r_owner;
            end
        end
    end

    assign bus.cpu_gnt    = r_cpu_gnt;
    assign bus.dbg_gnt    = r_dbg_gnt;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dbg_rdata  = bus.mem_rdata;
    assign bus.owner      = r_owner;
    assign bus.mem_cs     = r_mem_cs;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Vector table, corner sequences and random run for mem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .DBG_MAX_BURST(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram    [256];
    logic [7:0] shadow [256];

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00; bus.dbg_wdata = 8'h00;
        bus.hold_cpu = 1'b0;
    endtask

    function automatic logic [22:0] outs();
        return {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_rvalid, bus.dbg_rvalid,
                bus.mem_cs, bus.mem_we, bus.owner, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'(outs()), 32'h0);
        rst = 1'b1;
    endtask

    typedef struct {
        logic       cpu_req; logic cpu_we; logic [7:0] cpu_addr; logic [7:0] cpu_wdata;
        logic       dbg_req; logic dbg_we; logic [7:0] dbg_addr; logic [7:0] dbg_wdata;
        logic       hold;
        logic       e_cpu_gnt; logic e_dbg_gnt; logic e_we; logic e_owner;
        logic [7:0] e_addr; logic [7:0] e_wdata; logic e_rv; logic [7:0] e_rdata;
    } vec_t;

    vec_t vecs[8];

    // Reference model state (random phase)
    int         cyc, next_free, g_cyc, streak;
    bit         g_dbg, g_we, m_owner, cpu_el, cw;
    logic [7:0] m_addr, m_wdata, g_rdata;
    bit         cpu_pend, dbg_pend;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
        idle_inputs();
        do_reset();

        //                cpu: req  we    addr   wdata  dbg: req  we    addr   wdata  hold  | cg    dg    we    own   addr   wdata  rv    rdata
        vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 8'h48};
        vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'hA5, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00, 1'b1, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 8'h20, 8'h11, 1'b1, 1'b1, 8'h06, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 8'h77, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 8'h40, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 8'h77, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 8'h40, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'h3C, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 1'b1, 8'h48};
        vecs[7] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 1'b1, 8'h77};

        foreach (vecs[i]) begin
            bus.cpu_req = vecs[i].cpu_req; bus.cpu_we = vecs[i].cpu_we;
            bus.cpu_addr = vecs[i].cpu_addr; bus.cpu_wdata = vecs[i].cpu_wdata;
            bus.dbg_req = vecs[i].dbg_req; bus.dbg_we = vecs[i].dbg_we;
            bus.dbg_addr = vecs[i].dbg_addr; bus.dbg_wdata = vecs[i].dbg_wdata;
            bus.hold_cpu = vecs[i].hold;
            @(negedge clk);
            chk($sformatf("v%0d_cpu_gnt", i), 32'(bus.cpu_gnt), 32'(vecs[i].e_cpu_gnt));
            chk($sformatf("v%0d_dbg_gnt", i), 32'(bus.dbg_gnt), 32'(vecs[i].e_dbg_gnt));
            chk($sformatf("v%0d_mem_cs", i), 32'(bus.mem_cs), 32'(vecs[i].e_cpu_gnt | vecs[i].e_dbg_gnt));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_owner", i), 32'(bus.owner), 32'(vecs[i].e_owner));
            chk($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].e_wdata));
            idle_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(vecs[i].e_rv & vecs[i].e_cpu_gnt));
            chk($sformatf("v%0d_dbg_rvalid", i), 32'(bus.dbg_rvalid), 32'(vecs[i].e_rv & vecs[i].e_dbg_gnt));
            if (vecs[i].e_rv) begin
                if (vecs[i].e_cpu_gnt) chk($sformatf("v%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vecs[i].e_rdata));
                else                   chk($sformatf("v%0d_dbg_rdata", i), 32'(bus.dbg_rdata), 32'(vecs[i].e_rdata));
            end
            @(negedge clk);
            @(negedge clk);
        end

        // Starvation guard: both sides keep issuing writes.
        do_reset();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h80; bus.dbg_wdata = 8'hD0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h81; bus.cpu_wdata = 8'hC0;
        begin
            automatic string exp_seq = "DDDDCD";
            automatic string got_seq = "";
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (bus.cpu_gnt && bus.dbg_gnt) got_seq = {got_seq, "X"};
                else if (bus.cpu_gnt)           got_seq = {got_seq, "C"};
                else if (bus.dbg_gnt)           got_seq = {got_seq, "D"};
                if (bus.cpu_gnt || bus.dbg_gnt)
                    chk($sformatf("burst_owner_%0d", c), 32'(bus.owner), 32'(bus.dbg_gnt));
            end
            n_cmp++;
            if (got_seq != exp_seq) begin
                n_bad++;
                $display("FAIL burst_sequence: got %s expected %s", got_seq, exp_seq);
            end
        end
        idle_inputs();
        repeat (3) @(negedge clk);

        // hold_cpu blocks a lone CPU request until released.
        begin
            automatic int seen = 0;
            bus.cpu_req = 1'b1; bus.cpu_addr = 8'h12; bus.hold_cpu = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (bus.mem_cs || bus.cpu_gnt || bus.dbg_gnt) seen++;
            end
            chk("hold_no_grant", 32'(seen), 32'd0);
            bus.hold_cpu = 1'b0;
            @(negedge clk);
            chk("hold_release_gnt", 32'(bus.cpu_gnt), 32'd1);
            idle_inputs();
            repeat (3) @(negedge clk);
        end

        // Reset during a probe read ACCESS.
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h05;
        @(posedge clk);
        #1 chk("rst_mid_cs_before", 32'(bus.mem_cs), 32'd1);
        #1 rst = 1'b0;
        #1 chk("rst_mid_cs_async", 32'(bus.mem_cs), 32'd0);
        chk("rst_mid_gnt_async", 32'(bus.dbg_gnt), 32'd0);
        @(negedge clk);
        chk("rst_mid_outputs", 32'(outs()), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_gnt", 32'(bus.dbg_gnt), 32'd1);
        idle_inputs();
        @(negedge clk);
        chk("rst_release_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("rst_release_rdata", 32'(bus.dbg_rdata), 32'hA5);
        repeat (2) @(negedge clk);

        // Random traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = ram[i];
        cyc = 0; next_free = 0; g_cyc = -10; streak = 0;
        g_dbg = 0; g_we = 0; m_owner = 0; m_addr = 8'h00; m_wdata = 8'h00; g_rdata = 8'h00;
        cpu_pend = 0; dbg_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            cyc++;
            if (cyc >= next_free) begin
                cpu_el = bus.cpu_req && !bus.hold_cpu;
                if (bus.dbg_req || cpu_el) begin
                    cw      = cpu_el && (!bus.dbg_req || streak == MAXB);
                    g_dbg   = !cw;
                    g_we    = cw ? bus.cpu_we : bus.dbg_we;
                    m_addr  = cw ? bus.cpu_addr : bus.dbg_addr;
                    m_wdata = cw ? bus.cpu_wdata : bus.dbg_wdata;
                    m_owner = g_dbg;
                    if (g_we) shadow[m_addr] = m_wdata;
                    else      g_rdata = shadow[m_addr];
                    if (cw) streak = 0;
                    else if (cpu_el && streak < MAXB) streak++;
                    g_cyc     = cyc;
                    next_free = cyc + (g_we ? 2 : 3);
                end
            end
            @(negedge clk);
            begin
                automatic bit gc = (cyc == g_cyc);
                automatic bit rv = (cyc == g_cyc + 1) && !g_we;
                automatic logic [22:0] e = {gc & !g_dbg, gc & g_dbg, rv & !g_dbg, rv & g_dbg,
                                            gc, gc & g_we, m_owner, m_addr, m_wdata};
                chk($sformatf("rand_outs_c%0d", cyc), 32'(outs()), 32'(e));
                if (rv) chk($sformatf("rand_rdata_c%0d", cyc),
                            32'(g_dbg ? bus.dbg_rdata : bus.cpu_rdata), 32'(g_rdata));
            end
            if (cpu_pend && bus.cpu_gnt) cpu_pend = 0;
            if (dbg_pend && bus.dbg_gnt) dbg_pend = 0;
            if (!cpu_pend && ($urandom % 3 == 0)) begin
                cpu_pend = 1;
                bus.cpu_we = 1'($urandom % 2); bus.cpu_addr = 8'($urandom % 16); bus.cpu_wdata = 8'($urandom);
            end
            if (!dbg_pend && ($urandom % 4 == 0)) begin
                dbg_pend = 1;
                bus.dbg_we = 1'($urandom % 2); bus.dbg_addr = 8'($urandom % 16); bus.dbg_wdata = 8'($urandom);
            end
            bus.cpu_req = cpu_pend;
            bus.dbg_req = dbg_pend;
            if ($urandom % 8 == 0) bus.hold_cpu = !bus.hold_cpu;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
